// File: rtl/spi_transaction_fsm.sv
// ----------------------------------------------------------------------------
// spi_transaction_fsm
//
// Purpose: sequences one SPI slave transaction (address/command word followed
// by a data word) from pre-synchronized chip-select and serial-clock edge
// pulses. Drives the address latch, shift-register parallel load, data-memory
// write enable and MISO tri-state enable as registered one-state strobes.
//
// Parameters:
//   WIDTH     shift-register width; address and data words are WIDTH bits
//
// Ports:
//   clk       FPGA clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   cs_n      chip select, active-low, synchronized to clk
//   sclk_pos  one-clk pulse per serial-clock rising edge
//   sclk_neg  one-clk pulse per serial-clock falling edge
//   rw_bit    shift-register bit 0 in DECODE: 1 = read, 0 = write
//   addr_we   address latch capture strobe
//   sr_load   shift-register parallel-load strobe
//   dm_we     data-memory write enable strobe
//   miso_en   serial-out enable, high for the whole read shift phase
//   state     current state encoding (debug)
//   aborted   one-clk pulse after a mid-transaction chip-select release
//
// Build option:
//   SPI_FSM_ABORT_FLAG_EN  when defined, builds the aborted pulse register;
//                          otherwise aborted is constant 0.
// ----------------------------------------------------------------------------
module spi_transaction_fsm #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       rw_bit,
    output logic       addr_we,
    output logic       sr_load,
    output logic       dm_we,
    output logic       miso_en,
    output logic [2:0] state,
    output logic       aborted
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_GET_ADDR     = 3'd1,
        S_DECODE       = 3'd2,
        S_READ_LOAD    = 3'd3,
        S_READ_SHIFT   = 3'd4,
        S_WRITE_RECV   = 3'd5,
        S_WRITE_COMMIT = 3'd6,
        S_DONE         = 3'd7
    } state_t;

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_req;
    logic             addr_we_q, sr_load_q, dm_we_q, miso_en_q;

    // Chip select released while a transaction is in flight.
    assign abort_req = cs_n && (state_q != S_IDLE) && (state_q != S_DONE);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (!cs_n) state_d = S_GET_ADDR;
            end
            S_GET_ADDR: begin
                if (sclk_pos) begin
                    if (cnt_q == CNT_LAST) state_d = S_DECODE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = rw_bit ? S_READ_LOAD : S_WRITE_RECV;
            end
            S_READ_LOAD: begin
                state_d = S_READ_SHIFT;
            end
            S_READ_SHIFT: begin
                if (sclk_neg) begin
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE_RECV: begin
                if (sclk_pos) begin
                    if (cnt_q == CNT_LAST) state_d = S_WRITE_COMMIT;
                    else                   cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE_COMMIT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (cs_n) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any terminal-edge transition taken above, so a
        // simultaneous final pulse never reaches DECODE or WRITE_COMMIT.
        if (abort_req) state_d = S_IDLE;

        // Every state entry starts counting from zero; the edge pulse that
        // coincides with the entry is therefore not counted.
        if (state_d != state_q) cnt_d = '0;
    end

    // Strobes are decoded from the next state and registered alongside it, so
    // each is glitch-free and high exactly while the FSM sits in its state.
    // NOTE: asynchronous reset clears state and strobes immediately, without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_we_q <= 1'b0;
            sr_load_q <= 1'b0;
            dm_we_q   <= 1'b0;
            miso_en_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_we_q <= (state_d == S_DECODE);
            sr_load_q <= (state_d == S_READ_LOAD);
            dm_we_q   <= (state_d == S_WRITE_COMMIT);
            miso_en_q <= (state_d == S_READ_SHIFT);
        end
    end

`ifdef SPI_FSM_ABORT_FLAG_EN
    logic aborted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aborted_q <= 1'b0;
        else        aborted_q <= abort_req;
    end

    assign aborted = aborted_q;
`else
    assign aborted = 1'b0;
`endif

    assign addr_we = addr_we_q;
    assign sr_load = sr_load_q;
    assign dm_we   = dm_we_q;
    assign miso_en = miso_en_q;
    assign state   = state_q;

endmodule
